nibble_readout: RTL and testbench
=================================

NIBBLE_READOUT -- requirements
Module: nibble_readout

Interface
REQ-001 SHALL have parameter CHECKSUM_EN, default 1; 1 appends an XOR checksum beat to each frame.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one readout frame; sampled each cycle.
REQ-005 SHALL have ports in1, in2, in3, in4  input  4 each  operand register values.
REQ-006 SHALL have port result  input  4  block result value.
REQ-007 SHALL have port dout  output  4  current beat nibble.
REQ-008 SHALL have port dout_idx  output  3  current beat index, 0..5.
REQ-009 SHALL have port dout_valid  output  1  beat present on dout/dout_idx.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts beat.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, DONE.
REQ-014 IDLE: start=1 SHALL snapshot in1..in4 and result into internal registers, clear the beat counter, and enter SEND on the same edge.
REQ-015 Snapshot SHALL be frozen for the whole frame; input changes after the start edge SHALL NOT affect dout.
REQ-016 Beat order SHALL be idx0=in1, idx1=in2, idx2=in3, idx3=in4, idx4=result, idx5=in1^in2^in3^in4^result (snapshot values; idx5 only when CHECKSUM_EN=1).
REQ-017 Latency: start at edge N SHALL give dout_valid=1 with dout_idx=0 in the cycle after edge N.
REQ-018 In SEND, dout_valid SHALL be 1 and dout/dout_idx SHALL be stable until a cycle with dout_valid & dout_ready (a transfer).
REQ-019 A transfer SHALL advance to the next beat on that edge; with dout_ready held high, one beat SHALL transfer per cycle (6 cycles per frame with checksum, 5 without).
REQ-020 A transfer of the last beat SHALL enter DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 busy SHALL be 1 in SEND and DONE, 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-023 start in the DONE cycle SHALL be ignored; the earliest new frame is start in the following IDLE cycle.
REQ-024 dout_ready while dout_valid=0 SHALL have no effect.
REQ-025 In IDLE and DONE, dout and dout_idx SHALL be driven to 0.
REQ-026 Beat counter SHALL be 3 bits and SHALL never exceed the last beat index; no wrap past 5.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and clear the beat counter and snapshot registers, regardless of state.
REQ-028 After reset: dout=0, dout_idx=0, dout_valid=0, busy=0, done=0.
REQ-029 Reset mid-frame SHALL drop dout_valid on the next edge, with no done pulse.
REQ-030 rst and start high on the same edge: reset SHALL win.

Structure
REQ-031 The shared package SHALL hold the state enumeration, beat index constants (IDX_IN1..IDX_CHK) and the frame lengths (5 and 6).
REQ-032 The combinational beat-select SHALL be one sub-module, readout_mux, taking the snapshot and index and returning the nibble; the FSM, counter and snapshot SHALL stay in nibble_readout.

Verification
REQ-033 in1..4=3,5,6,9, result=A, ready=1, one-cycle start -> dout 3,5,6,9,A,3 on idx 0..5 in 6 consecutive cycles; done pulses once on the next cycle.
REQ-034 Same stimulus, ready low except every third cycle -> each beat is held stable until accepted, same sequence, done only after the idx5 transfer.
REQ-035 Inputs change to F,F,F,F,F one cycle after start -> the transmitted frame is still 3,5,6,9,A,3.
REQ-036 Second start pulse during beat 2, and start held high through DONE -> the first frame is unaffected; a new frame starts only in the IDLE cycle after DONE.
REQ-037 rst asserted while idx=3 is presented -> next cycle valid=0, busy=0, dout=0; no done pulse.
REQ-038 CHECKSUM_EN=0, same inputs -> 5 beats (3,5,6,9,A); done in the cycle after idx4.

Source files
------------

// File: rtl/nibble_readout_pkg.sv
// Shared types and constants for the nibble readout block: FSM states,
// beat indices, frame lengths and the snapshot record.
package nibble_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] IDX_IN1 = 3'd0;
    localparam logic [2:0] IDX_IN2 = 3'd1;
    localparam logic [2:0] IDX_IN3 = 3'd2;
    localparam logic [2:0] IDX_IN4 = 3'd3;
    localparam logic [2:0] IDX_RES = 3'd4;
    localparam logic [2:0] IDX_CHK = 3'd5;

    localparam int FRAME_LEN_NOCHK = 5;
    localparam int FRAME_LEN_CHK   = 6;

    typedef struct packed {
        logic [3:0] in1;
        logic [3:0] in2;
        logic [3:0] in3;
        logic [3:0] in4;
        logic [3:0] res;
    } snap_t;

    function automatic logic [2:0] last_idx(input int checksum_en);
        if (checksum_en != 0) begin
            return 3'(FRAME_LEN_CHK - 1);
        end
        return 3'(FRAME_LEN_NOCHK - 1);
    endfunction

endpackage

// File: rtl/nibble_readout_mux.sv
// Combinational beat select: maps a beat index onto the frozen snapshot,
// producing the XOR checksum nibble for the final index.
module readout_mux
    import nibble_readout_pkg::*;
(
    input  snap_t      snap,
    input  logic [2:0] idx,
    output logic [3:0] nibble
);

    logic [3:0] chk;

    // Checksum bit gi is the parity of bit gi across all five fields.
    for (genvar gi = 0; gi < 4; gi++) begin : g_chk
        assign chk[gi] = ^{snap.in1[gi], snap.in2[gi], snap.in3[gi], snap.in4[gi], snap.res[gi]};
    end

    always_comb begin
        nibble = 4'd0;
        case (idx)
            IDX_IN1: nibble = snap.in1;
            IDX_IN2: nibble = snap.in2;
            IDX_IN3: nibble = snap.in3;
            IDX_IN4: nibble = snap.in4;
            IDX_RES: nibble = snap.res;
            IDX_CHK: nibble = chk;
            default: nibble = 4'd0;
        endcase
    end

endmodule

// File: rtl/nibble_readout.sv
// Frame sequencer: snapshots operands on start and streams them as a
// valid/ready nibble frame, optionally followed by an XOR checksum beat.
module nibble_readout
    import nibble_readout_pkg::*;
#(
    parameter int CHECKSUM_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] in4,
    input  logic [3:0] result,
    output logic [3:0] dout,
    output logic [2:0] dout_idx,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_IDX = last_idx(CHECKSUM_EN);

    state_t     state_reg, state_next;
    logic [2:0] beat_reg, beat_next;
    snap_t      snap_reg, snap_next;
    logic [3:0] mux_nibble;

    readout_mux u_mux (
        .snap   (snap_reg),
        .idx    (beat_reg),
        .nibble (mux_nibble)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            beat_reg  <= 3'd0;
            snap_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            snap_reg  <= snap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        snap_next  = snap_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    snap_next  = '{in1: in1, in2: in2, in3: in3, in4: in4, res: result};
                    beat_next  = 3'd0;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                // The counter saturates on the last beat; DONE is entered instead.
                if (dout_ready) begin
                    if (beat_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        beat_next = beat_reg + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        dout_valid = (state_reg == ST_SEND);
        busy       = (state_reg != ST_IDLE);
        done       = (state_reg == ST_DONE);
        dout       = dout_valid ? mux_nibble : 4'd0;
        dout_idx   = dout_valid ? beat_reg : 3'd0;
    end

endmodule

// File: tb/tb_nibble_readout.sv
// Directed bench for nibble_readout: checksum and no-checksum instances,
// backpressure, snapshot freezing, start filtering and mid-frame reset.
module tb_nibble_readout;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start0;
    logic [3:0] in1, in2, in3, in4, result;
    logic       dout_ready;

    logic [3:0] dout, dout0;
    logic [2:0] dout_idx, dout_idx0;
    logic       dout_valid, dout_valid0;
    logic       busy, busy0;
    logic       done, done0;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_frame [6];

    always #5 clk = ~clk;

    nibble_readout #(.CHECKSUM_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .in4        (in4),
        .result     (result),
        .dout       (dout),
        .dout_idx   (dout_idx),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    nibble_readout #(.CHECKSUM_EN(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .in4        (in4),
        .result     (result),
        .dout       (dout0),
        .dout_idx   (dout_idx0),
        .dout_valid (dout_valid0),
        .dout_ready (dout_ready),
        .busy       (busy0),
        .done       (done0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-24s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_beat(input string tc, input int i);
        check($sformatf("%s valid%0d", tc, i), 8'(dout_valid), 8'd1);
        check($sformatf("%s idx%0d", tc, i), 8'(dout_idx), 8'(i));
        check($sformatf("%s dout%0d", tc, i), 8'(dout), 8'(exp_frame[i]));
    endtask

    task automatic check_idle(input string tc);
        check({tc, " valid"}, 8'(dout_valid), 8'd0);
        check({tc, " busy"}, 8'(busy), 8'd0);
        check({tc, " done"}, 8'(done), 8'd0);
        check({tc, " dout"}, 8'(dout), 8'd0);
        check({tc, " idx"}, 8'(dout_idx), 8'd0);
    endtask

    // Beats first..5 with ready high, then the done cycle, then idle.
    task automatic finish_frame(input string tc, input int first);
        dout_ready = 1'b1;
        for (int i = first; i < 6; i++) begin
            check_beat(tc, i);
            check($sformatf("%s nodone%0d", tc, i), 8'(done), 8'd0);
            step();
        end
        check({tc, " done"}, 8'(done), 8'd1);
        check({tc, " done busy"}, 8'(busy), 8'd1);
        check({tc, " done valid"}, 8'(dout_valid), 8'd0);
        check({tc, " done dout"}, 8'(dout), 8'd0);
        step();
        check_idle({tc, " after"});
    endtask

    task automatic set_inputs(input logic [3:0] a, b, c, d, r);
        in1 = a; in2 = b; in3 = c; in4 = d; result = r;
    endtask

    initial begin
        exp_frame[0] = 4'h3; exp_frame[1] = 4'h5; exp_frame[2] = 4'h6;
        exp_frame[3] = 4'h9; exp_frame[4] = 4'hA; exp_frame[5] = 4'h3;

        rst = 1'b1; start = 1'b0; start0 = 1'b0; dout_ready = 1'b0;
        set_inputs(4'h3, 4'h5, 4'h6, 4'h9, 4'hA);
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset valid0", 8'(dout_valid0), 8'd0);
        check("reset busy0", 8'(busy0), 8'd0);

        // Ready held high: one beat per cycle.
        dout_ready = 1'b1;
        step();
        check_idle("ready idle");
        start = 1'b1;
        step();
        start = 1'b0;
        finish_frame("basic", 0);

        // Backpressure: ready only every third cycle.
        start = 1'b1;
        dout_ready = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dout_ready = 1'b0;
            for (int w = 0; w < 2; w++) begin
                check_beat("bp hold", i);
                check("bp nodone", 8'(done), 8'd0);
                step();
            end
            dout_ready = 1'b1;
            check_beat("bp xfer", i);
            check("bp nodone x", 8'(done), 8'd0);
            step();
        end
        check("bp done", 8'(done), 8'd1);
        step();
        check_idle("bp after");

        // Inputs change one cycle after start: snapshot must hold.
        start = 1'b1;
        step();
        start = 1'b0;
        set_inputs(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        finish_frame("frozen", 0);
        set_inputs(4'h3, 4'h5, 4'h6, 4'h9, 4'hA);

        // Start pulse during beat 2, then start held through DONE.
        start = 1'b1;
        step();
        start = 1'b0;
        check_beat("busy start", 0);
        step();
        check_beat("busy start", 1);
        step();
        check_beat("busy start", 2);
        start = 1'b1;
        step();
        start = 1'b0;
        check_beat("busy start", 3);
        step();
        check_beat("busy start", 4);
        start = 1'b1;
        step();
        check_beat("busy start", 5);
        step();
        check("held done", 8'(done), 8'd1);
        step();
        check("held idle busy", 8'(busy), 8'd0);
        check("held idle valid", 8'(dout_valid), 8'd0);
        check("held idle done", 8'(done), 8'd0);
        step();
        start = 1'b0;
        finish_frame("restart", 0);

        // Reset while idx3 is presented.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat("midrst", i);
            step();
        end
        check_beat("midrst", 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midrst");
        step();
        check_idle("midrst later");

        // Reset and start on the same edge: reset wins.
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        check_idle("rst+start");
        step();
        check_idle("rst+start later");

        // No-checksum instance: five beats, done after idx4.
        start0 = 1'b1;
        dout_ready = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("nochk valid%0d", i), 8'(dout_valid0), 8'd1);
            check($sformatf("nochk idx%0d", i), 8'(dout_idx0), 8'(i));
            check($sformatf("nochk dout%0d", i), 8'(dout0), 8'(exp_frame[i]));
            check($sformatf("nochk nodone%0d", i), 8'(done0), 8'd0);
            step();
        end
        check("nochk done", 8'(done0), 8'd1);
        check("nochk done valid", 8'(dout_valid0), 8'd0);
        step();
        check("nochk idle busy", 8'(busy0), 8'd0);
        check("nochk idle done", 8'(done0), 8'd0);
        check("main untouched", 8'(busy), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
